mem_access_ctrl: RTL and testbench

- MEM-stage initiator that drives the data memory port: the memRead/memWrite/en32/address/data_in side, and the capture of data_out.
- Accepts one request at a time from the pipeline and sequences the single-cycle memory access.
- Captures read data one cycle after the access.
- Owns the stack pointer (SP) for PUSH/POP and for 32-bit PC save/restore on CALL/RET/INT/RTI.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/sp_unit.sv | 68 ++++++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage memory access controller:
// op encoding, FSM state encoding, address width and stack defaults,
// plus small op-decode helpers used by the controller.
package mem_pkg;

  localparam int                    MEM_ADDR_W      = 20;
  localparam logic [MEM_ADDR_W-1:0] SP_RESET_DEF    = 20'hFFFFF;
  localparam logic [MEM_ADDR_W-1:0] STACK_LIMIT_DEF = 20'h80000;

  localparam logic [2:0] OP_LD16   = 3'b000;
  localparam logic [2:0] OP_ST16   = 3'b001;
  localparam logic [2:0] OP_LD32   = 3'b010;
  localparam logic [2:0] OP_ST32   = 3'b011;
  localparam logic [2:0] OP_PUSH16 = 3'b100;
  localparam logic [2:0] OP_POP16  = 3'b101;
  localparam logic [2:0] OP_PUSH32 = 3'b110;
  localparam logic [2:0] OP_POP32  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Memory write ops: stores and pushes; everything else reads.
  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_ST16) || (op == OP_ST32) ||
           (op == OP_PUSH16) || (op == OP_PUSH32);
  endfunction

  function automatic logic op_is_32(input logic [2:0] op);
    return (op == OP_LD32) || (op == OP_ST32) ||
           (op == OP_PUSH32) || (op == OP_POP32);
  endfunction

endpackage

// File: rtl/sp_unit.sv
// Stack pointer unit. Holds SP, computes the effective address for the
// current op and the SP update, and flags push overflow / pop underflow.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   op, address       op in IDLE and LD/ST word address
//   accept            request accepted this edge (SP commits unless refused)
//   sp                current SP
//   ea                effective address for op (combinational)
//   ovf, unf          guard results for op against current SP (combinational)
module sp_unit import mem_pkg::*; #(
  parameter int                ADDR_W      = MEM_ADDR_W,
  parameter logic [ADDR_W-1:0] SP_RESET    = SP_RESET_DEF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] address,
  input  logic              accept,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] ea,
  output logic              ovf,
  output logic              unf
);

  logic [ADDR_W-1:0] sp_nxt;

  // Guards are written so no term can wrap: PUSH32 needs SP-1 >= limit,
  // POP32 needs SP+2 <= reset value (checked one bit wider).
  always_comb begin
    ea     = address;
    sp_nxt = sp;
    ovf    = 1'b0;
    unf    = 1'b0;
    case (op)
      OP_PUSH16: begin
        ea     = sp;
        sp_nxt = sp - ADDR_W'(1);
        ovf    = (sp < STACK_LIMIT);
      end
      OP_PUSH32: begin
        // Low half at SP-1, high half at the old SP.
        ea     = sp - ADDR_W'(1);
        sp_nxt = sp - ADDR_W'(2);
        ovf    = (sp <= STACK_LIMIT);
      end
      OP_POP16: begin
        ea     = sp + ADDR_W'(1);
        sp_nxt = sp + ADDR_W'(1);
        unf    = (sp >= SP_RESET);
      end
      OP_POP32: begin
        ea     = sp + ADDR_W'(1);
        sp_nxt = sp + ADDR_W'(2);
        unf    = (({1'b0, sp} + (ADDR_W+1)'(2)) > {1'b0, SP_RESET});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      sp <= SP_RESET;
    else if (accept && !ovf && !unf)
      sp <= sp_nxt;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller. Accepts one request in IDLE,
// performs a single-cycle access on the data memory port, captures read
// data the cycle after the access and signals completion with o_done.
// Stack ops use the SP held in sp_unit; refused stack ops skip memory.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_req_valid/i_op/i_address/i_wdata   request (sampled when o_ready)
//   o_ready, o_done, o_rdata    handshake and load/pop result
//   o_stack_ovf, o_stack_unf    refused push / pop, valid with o_done
//   o_sp                        current stack pointer
//   o_memRead/o_memWrite/o_en32/o_address/o_data_in   memory port
//   i_data_out                  registered memory read data
module mem_access_ctrl import mem_pkg::*; #(
  parameter int                ADDR_W      = MEM_ADDR_W,
  parameter logic [ADDR_W-1:0] SP_RESET    = SP_RESET_DEF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_stack_ovf,
  output logic              o_stack_unf,
  output logic [ADDR_W-1:0] o_sp,
  output logic              o_memRead,
  output logic              o_memWrite,
  output logic              o_en32,
  output logic [ADDR_W-1:0] o_address,
  output logic [31:0]       o_data_in,
  input  logic [31:0]       i_data_out
);

  state_e            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] ea;
  logic              ovf, unf;
  logic              accept;

  assign accept = (state == ST_IDLE) && i_req_valid;

  sp_unit #(
    .ADDR_W     (ADDR_W),
    .SP_RESET   (SP_RESET),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_sp (
    .clk    (clk),
    .rst    (rst),
    .op     (i_op),
    .address(i_address),
    .accept (accept),
    .sp     (o_sp),
    .ea     (ea),
    .ovf    (ovf),
    .unf    (unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_LD16;
      o_ready     <= 1'b1;
      o_done      <= 1'b0;
      o_rdata     <= '0;
      o_stack_ovf <= 1'b0;
      o_stack_unf <= 1'b0;
      o_memRead   <= 1'b0;
      o_memWrite  <= 1'b0;
      o_en32      <= 1'b0;
      o_address   <= '0;
      o_data_in   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            op_q    <= i_op;
            o_ready <= 1'b0;
            o_rdata <= '0;
            if (ovf || unf) begin
              // Refused stack op: straight to completion, no access.
              state       <= ST_DONE;
              o_done      <= 1'b1;
              o_stack_ovf <= ovf;
              o_stack_unf <= unf;
            end else begin
              state      <= ST_ACCESS;
              o_memWrite <= op_is_write(i_op);
              o_memRead  <= !op_is_write(i_op);
              o_en32     <= op_is_32(i_op);
              o_address  <= ea;
              o_data_in  <= op_is_32(i_op) ? i_wdata : {16'h0000, i_wdata[15:0]};
            end
          end
        end
        ST_ACCESS: begin
          o_memRead  <= 1'b0;
          o_memWrite <= 1'b0;
          o_en32     <= 1'b0;
          o_address  <= '0;
          o_data_in  <= '0;
          if (op_is_write(op_q)) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Memory data is only looked at here, so a floating bus
          // outside reads never reaches o_rdata.
          o_rdata <= op_is_32(op_q) ? i_data_out : {16'h0000, i_data_out[15:0]};
          state   <= ST_DONE;
          o_done  <= 1'b1;
        end
        ST_DONE: begin
          o_done      <= 1'b0;
          o_stack_ovf <= 1'b0;
          o_stack_unf <= 1'b0;
          o_ready     <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory on the port side, request-level
// reference model (SP, guards, memory image), directed cases then random.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam logic [19:0] P_SP_RESET = 20'hFFFFF;
  localparam logic [19:0] P_LIMIT    = 20'hFFFF0; // small stack so both guards get hit
  localparam int          M_RESET    = 'hFFFFF;
  localparam int          M_LIMIT    = 'hFFFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [2:0]  i_op = 3'b000;
  logic [19:0] i_address = '0;
  logic [31:0] i_wdata = '0;
  logic        o_ready, o_done, o_stack_ovf, o_stack_unf;
  logic [31:0] o_rdata, o_data_in;
  logic [19:0] o_sp, o_address;
  logic        o_memRead, o_memWrite, o_en32;
  logic [31:0] i_data_out = 'z;

  mem_access_ctrl #(
    .ADDR_W(20), .SP_RESET(P_SP_RESET), .STACK_LIMIT(P_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .i_op(i_op),
    .i_address(i_address), .i_wdata(i_wdata), .o_ready(o_ready),
    .o_done(o_done), .o_rdata(o_rdata), .o_stack_ovf(o_stack_ovf),
    .o_stack_unf(o_stack_unf), .o_sp(o_sp), .o_memRead(o_memRead),
    .o_memWrite(o_memWrite), .o_en32(o_en32), .o_address(o_address),
    .o_data_in(o_data_in), .i_data_out(i_data_out)
  );

  always #5 clk = ~clk;

  logic [15:0] bus_mem [int];
  logic [15:0] ref_mem [int];
  int          errs = 0, checks = 0, acc_cnt = 0;
  int          m_sp = M_RESET;
  logic [31:0] obs_rd;
  logic        obs_ovf, obs_unf;

  function automatic logic [15:0] bus_rd(input int a);
    return bus_mem.exists(a) ? bus_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  // Memory: registered read, z when idle; junk in the upper half of
  // 16-bit reads so masking is exercised. a+1 is not wrapped.
  always @(posedge clk) begin
    if (o_memWrite === 1'b1) begin
      bus_mem[int'(o_address)] = o_data_in[15:0];
      if (o_en32) bus_mem[int'(o_address) + 1] = o_data_in[31:16];
    end
    if (o_memRead === 1'b1)
      i_data_out <= o_en32 ? {bus_rd(int'(o_address) + 1), bus_rd(int'(o_address))}
                           : {16'hDEAD, bus_rd(int'(o_address))};
    else
      i_data_out <= 'z;
  end

  always @(negedge clk)
    if (o_memRead === 1'b1 || o_memWrite === 1'b1) acc_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    i_req_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
    m_sp = M_RESET;
  endtask

  // One request through the model and the DUT. hold keeps i_req_valid
  // high with junk op/data while the DUT is busy.
  task automatic do_req(input logic [2:0] op, input logic [19:0] addr,
                        input logic [31:0] wd, input bit hold);
    bit          rd = 0, wr = 0, e32 = 0, ovf = 0, unf = 0;
    int          ea, nsp, lat, n, acc0, w;
    logic [31:0] exp_rd = '0;
    nsp = m_sp;
    ea  = int'(addr);
    case (op)
      OP_LD16: rd = 1;
      OP_ST16: wr = 1;
      OP_LD32: begin rd = 1; e32 = 1; end
      OP_ST32: begin wr = 1; e32 = 1; end
      OP_PUSH16: if (m_sp < M_LIMIT) ovf = 1;
                 else begin wr = 1; ea = m_sp; nsp = m_sp - 1; end
      OP_PUSH32: if (m_sp < M_LIMIT + 1) ovf = 1;
                 else begin wr = 1; e32 = 1; ea = m_sp - 1; nsp = m_sp - 2; end
      OP_POP16:  if (m_sp > M_RESET - 1) unf = 1;
                 else begin rd = 1; ea = m_sp + 1; nsp = m_sp + 1; end
      default:   if (m_sp > M_RESET - 2) unf = 1;
                 else begin rd = 1; e32 = 1; ea = m_sp + 1; nsp = m_sp + 2; end
    endcase
    if (wr) begin
      ref_mem[ea] = wd[15:0];
      if (e32) ref_mem[ea + 1] = wd[31:16];
    end
    if (rd) exp_rd = e32 ? {ref_rd(ea + 1), ref_rd(ea)} : {16'h0000, ref_rd(ea)};
    lat = (ovf || unf) ? 1 : (rd ? 3 : 2);

    w = 0;
    while (o_ready !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    if (o_ready !== 1'b1) begin chk("ready_timeout", o_ready, 1); return; end

    i_req_valid = 1'b1; i_op = op; i_address = addr; i_wdata = wd;
    acc0 = acc_cnt;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        if (hold) begin i_op = 3'($urandom); i_address = 20'($urandom); i_wdata = $urandom; end
        else i_req_valid = 1'b0;
        chk("ready_busy", o_ready, 0);
        if (lat > 1) begin
          chk("memRead", o_memRead, rd);
          chk("memWrite", o_memWrite, wr);
          chk("en32", o_en32, e32);
          chk("address", o_address, ea);
          if (wr) chk("data_in", e32 ? o_data_in : {16'h0, o_data_in[15:0]},
                                 e32 ? wd : {16'h0, wd[15:0]});
          chk("sp_access", o_sp, nsp);
        end
      end else if (o_done !== 1'b1) begin
        chk("en_off", {o_memRead, o_memWrite}, 0);
      end
    end while (o_done !== 1'b1 && n < 8);

    chk("latency", n, lat);
    chk("done", o_done, 1);
    chk("rdata", o_rdata, exp_rd);
    chk("ovf", o_stack_ovf, ovf);
    chk("unf", o_stack_unf, unf);
    chk("sp_done", o_sp, nsp);
    chk("en_done", {o_memRead, o_memWrite}, 0);
    chk("acc_count", acc_cnt - acc0, (lat > 1) ? 1 : 0);
    obs_rd = o_rdata; obs_ovf = o_stack_ovf; obs_unf = o_stack_unf;
    m_sp = nsp;
    if (hold) i_req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset(3);
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_sp", o_sp, 20'hFFFFF);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_flags", {o_stack_ovf, o_stack_unf}, 0);
    chk("rst_en", {o_memRead, o_memWrite, o_en32}, 0);
    chk("rst_addr", o_address, 0);
    chk("rst_din", o_data_in, 0);

    // PUSH16 after reset
    do_req(OP_PUSH16, 20'h0, 32'h0000ABCD, 0);
    chk("push16_sp", o_sp, 20'hFFFFE);

    // PUSH32 then POP32
    do_reset(2);
    do_req(OP_PUSH32, 20'h0, 32'h12345678, 0);
    chk("ram_lo", bus_rd('hFFFFE), 16'h5678);
    chk("ram_hi", bus_rd('hFFFFF), 16'h1234);
    do_req(OP_POP32, 20'h0, 32'h0, 0);
    chk("pop32_rdata", obs_rd, 32'h12345678);
    chk("pop32_sp", o_sp, 20'hFFFFF);

    // POP16 on empty stack
    do_reset(2);
    do_req(OP_POP16, 20'h0, 32'h0, 0);
    chk("pop16_unf", obs_unf, 1);

    // ST16 / LD16 / LD32
    do_req(OP_ST16, 20'h00010, 32'hFFFFBEEF, 0);
    do_req(OP_LD16, 20'h00010, 32'h0, 0);
    chk("ld16_rdata", obs_rd, 32'h0000BEEF);
    do_req(OP_LD32, 20'h0000F, 32'h0, 0);
    chk("ld32_hi", obs_rd[31:16], 16'hBEEF);

    // 32-bit access at the top word address
    do_req(OP_ST32, 20'hFFFFF, 32'hCAFEF00D, 0);
    do_req(OP_LD32, 20'hFFFFF, 32'h0, 0);

    // Request held valid while busy
    do_req(OP_LD16, 20'h00010, 32'h0, 1);
    do_req(OP_ST32, 20'h00020, 32'h13579BDF, 1);
    do_req(OP_LD32, 20'h00020, 32'h0, 1);

    // Reset during CAPTURE of a POP16
    do_reset(2);
    do_req(OP_PUSH16, 20'h0, 32'h00005A5A, 0);
    for (int k = 0; k < 10 && o_ready !== 1'b1; k++) @(negedge clk);
    i_req_valid = 1'b1; i_op = OP_POP16;
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("mid_access_rd", o_memRead, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_en", {o_memRead, o_memWrite, o_en32}, 0);
    chk("mid_ready", o_ready, 1);
    chk("mid_sp", o_sp, 20'hFFFFF);
    chk("mid_done", o_done, 0);
    rst = 1'b0;
    m_sp = M_RESET;
    repeat (3) begin @(negedge clk); chk("mid_no_done", o_done, 0); end

    // Stack limit boundaries
    do_reset(2);
    repeat (15) do_req(OP_PUSH16, 20'h0, $urandom, 0);
    chk("bnd_sp_limit", o_sp, 20'hFFFF0);
    do_req(OP_PUSH32, 20'h0, $urandom, 0);
    chk("bnd_ovf32", obs_ovf, 1);
    do_req(OP_PUSH16, 20'h0, $urandom, 0);
    chk("bnd_push16_ok", obs_ovf, 0);
    do_req(OP_PUSH16, 20'h0, $urandom, 0);
    chk("bnd_ovf16", obs_ovf, 1);
    repeat (7) do_req(OP_POP32, 20'h0, 32'h0, 0);
    do_req(OP_POP16, 20'h0, 32'h0, 0);
    do_req(OP_POP32, 20'h0, 32'h0, 0);
    chk("bnd_unf32", obs_unf, 1);
    do_req(OP_POP16, 20'h0, 32'h0, 0);
    chk("bnd_pop16_ok", obs_unf, 0);
    do_req(OP_POP16, 20'h0, 32'h0, 0);
    chk("bnd_unf16", obs_unf, 1);

    // Random traffic
    for (int r = 0; r < 250; r++) begin
      logic [19:0] a;
      case ($urandom_range(0, 3))
        0: a = 20'hFFFFF;
        1: a = 20'hFFFFE;
        2: a = 20'($urandom);
        default: a = 20'($urandom_range(0, 31));
      endcase
      do_req(3'($urandom_range(0, 7)), a, $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
